// File: rtl/alu_controller.sv
// Command sequencer for the 5x5 matrix ALU: accepts one operation, drives the
// ALU for as long as the opcode needs, and returns result/overflow/error.
module alu_controller #(
  parameter int MUL_TIMEOUT = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_opcode,
  input  logic [199:0] cmd_A,
  input  logic [199:0] cmd_B,
  input  logic [7:0]   cmd_f,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [199:0] rsp_C,
  output logic         rsp_overflow,
  output logic [1:0]   rsp_error,
  output logic         busy,
  output logic [199:0] alu_A,
  output logic [199:0] alu_B,
  output logic [7:0]   alu_f,
  output logic [2:0]   alu_opcode,
  input  logic [199:0] alu_C,
  input  logic         alu_overflow,
  input  logic         alu_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DET  = 3'b111;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int CW = (MUL_TIMEOUT < 1) ? 1 : $clog2(MUL_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO  = CW'(MUL_TIMEOUT);
  localparam logic [CW-1:0] CMAX = '1;

  logic [1:0]    state;
  logic [2:0]    op_q;
  logic [199:0]  a_q;
  logic [199:0]  b_q;
  logic [7:0]    f_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          capture;

  // Saturating increment: the counter must never wrap back below the limit.
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + CW'(1);

  // Non-multiply ops complete in their first WAIT cycle; done wins over timeout.
  assign capture = (op_q != OP_MUL) || alu_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      f_q          <= '0;
      cnt          <= '0;
      rsp_C        <= '0;
      rsp_overflow <= 1'b0;
      rsp_error    <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_opcode;
            a_q  <= cmd_A;
            b_q  <= cmd_B;
            f_q  <= cmd_f;
            if (cmd_opcode == OP_NONE || cmd_opcode == OP_DET) begin
              rsp_C        <= '0;
              rsp_overflow <= 1'b0;
              rsp_error    <= ERR_ILLEGAL;
              state        <= RESP;
            end else begin
              cnt   <= '0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (capture) begin
            rsp_C        <= alu_C;
            rsp_overflow <= alu_overflow;
            rsp_error    <= ERR_OK;
            state        <= RESP;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= TMO) begin
              rsp_C        <= '0;
              rsp_overflow <= 1'b0;
              rsp_error    <= ERR_TIMEOUT;
              state        <= RESP;
            end
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);
  assign alu_opcode = (state == ISSUE || state == WAIT) ? op_q : OP_NONE;
  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_f      = f_q;

endmodule

// File: tb/tb_alu_controller.sv
// Directed bench for alu_controller with a behavioural matrix ALU model.
module tb_alu_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_opcode;
  logic [199:0] cmd_A;
  logic [199:0] cmd_B;
  logic [7:0]   cmd_f;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [199:0] rsp_C;
  logic         rsp_overflow;
  logic [1:0]   rsp_error;
  logic         busy;
  logic [199:0] alu_A;
  logic [199:0] alu_B;
  logic [7:0]   alu_f;
  logic [2:0]   alu_opcode;
  logic [199:0] alu_C;
  logic         alu_overflow;
  logic         alu_done;

  int errors = 0;
  int checks = 0;
  int done_at = -1;
  int mul_cyc = 0;

  always #5 clock = ~clock;

  alu_controller #(.MUL_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_f(cmd_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_C(rsp_C),
    .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .busy(busy),
    .alu_A(alu_A), .alu_B(alu_B), .alu_f(alu_f), .alu_opcode(alu_opcode),
    .alu_C(alu_C), .alu_overflow(alu_overflow), .alu_done(alu_done)
  );

  function automatic logic [200:0] alu_model(input logic [2:0] op, input logic [199:0] a,
                                             input logic [199:0] b, input logic [7:0] f);
    logic [199:0] c;
    logic ovf;
    logic signed [7:0] ea, eb, ef;
    logic signed [15:0] r;
    c = '0;
    ovf = 1'b0;
    if (op == 3'b011) return {1'b0, {25{8'h55}}};
    for (int i = 0; i < 25; i++) begin
      ea = a[i*8 +: 8];
      eb = b[i*8 +: 8];
      ef = f;
      case (op)
        3'b001:  r = ea + eb;
        3'b010:  r = ea - eb;
        3'b100:  r = -ea;
        3'b101:  begin ea = a[((i % 5) * 5 + i / 5) * 8 +: 8]; r = ea; end
        3'b110:  r = ea * ef;
        default: r = '0;
      endcase
      c[i*8 +: 8] = r[7:0];
      if (r > 16'sd127 || r < -16'sd128) ovf = 1'b1;
    end
    return {ovf, c};
  endfunction

  always_comb {alu_overflow, alu_C} = alu_model(alu_opcode, alu_A, alu_B, alu_f);
  assign alu_done = (alu_opcode == 3'b011) && (mul_cyc == done_at);

  always @(posedge clock) begin
    if (alu_opcode == 3'b011) mul_cyc <= mul_cyc + 1;
    else mul_cyc <= 0;
  end

  typedef struct {
    logic [2:0] opcode;
    logic [7:0] a, b, f;
    int         done_at;
    int         hold;
    logic [7:0] exp_c;
    logic       exp_ovf;
    logic [1:0] exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, b, f, input int dat,
                              input int hold, input logic [7:0] c, input logic ovf,
                              input logic [1:0] err, input int lat);
    vec_t v;
    v.opcode = op; v.a = a; v.b = b; v.f = f; v.done_at = dat; v.hold = hold;
    v.exp_c = c; v.exp_ovf = ovf; v.exp_err = err; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [2:0]   exp_op;
    logic [199:0] c0;
    logic         o0;
    logic [1:0]   e0;
    int           lat;
    bit           op_ok, stable;
    done_at = v.done_at;
    exp_op = (v.opcode == 3'b000 || v.opcode == 3'b111) ? 3'b000 : v.opcode;
    @(negedge clock);
    cmd_opcode = v.opcode;
    cmd_A = {25{v.a}};
    cmd_B = {25{v.b}};
    cmd_f = v.f;
    cmd_valid = 1'b1;
    chk($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
    lat = 1;
    op_ok = 1'b1;
    while (!rsp_valid && lat < 100) begin
      if (alu_opcode !== exp_op || busy !== 1'b1) op_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    if (alu_opcode !== 3'b000) op_ok = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_opcode_trace", idx), op_ok, 1);
    chk($sformatf("v%0d_rsp_C", idx), rsp_C, {25{v.exp_c}});
    chk($sformatf("v%0d_rsp_overflow", idx), rsp_overflow, v.exp_ovf);
    chk($sformatf("v%0d_rsp_error", idx), rsp_error, v.exp_err);
    chk($sformatf("v%0d_alu_A", idx), alu_A, {25{v.a}});
    if (v.hold > 0) begin
      c0 = rsp_C; o0 = rsp_overflow; e0 = rsp_error;
      stable = 1'b1;
      cmd_valid = 1'b1;
      cmd_opcode = 3'b001;
      cmd_A = {25{8'h01}};
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clock);
        if (rsp_valid !== 1'b1 || rsp_C !== c0 || rsp_overflow !== o0 || rsp_error !== e0 ||
            cmd_ready !== 1'b0 || alu_opcode !== 3'b000 || alu_A !== {25{v.a}}) stable = 1'b0;
      end
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_backpressure_stable", idx), stable, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_valid_drop", idx), rsp_valid, 0);
    chk($sformatf("v%0d_cmd_ready_after", idx), {busy, cmd_ready}, 2'b01);
  endtask

  initial begin
    bit never;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_opcode = '0;
    cmd_A = '0;
    cmd_B = '0;
    cmd_f = '0;
    rsp_ready = 1'b0;

    vecs.push_back(mk(3'b001, 8'h03, 8'h04, 8'h00, -1,  0, 8'h07, 1'b0, 2'b00, 3));
    vecs.push_back(mk(3'b010, 8'h05, 8'h09, 8'h00, -1,  0, 8'hFC, 1'b0, 2'b00, 3));
    vecs.push_back(mk(3'b010, 8'h80, 8'h01, 8'h00, -1,  0, 8'h7F, 1'b1, 2'b00, 3));
    vecs.push_back(mk(3'b001, 8'h64, 8'h64, 8'h00, -1,  0, 8'hC8, 1'b1, 2'b00, 3));
    vecs.push_back(mk(3'b100, 8'h05, 8'h00, 8'h00, -1,  0, 8'hFB, 1'b0, 2'b00, 3));
    vecs.push_back(mk(3'b100, 8'h80, 8'h00, 8'h00, -1,  0, 8'h80, 1'b1, 2'b00, 3));
    vecs.push_back(mk(3'b101, 8'h12, 8'h34, 8'h00, -1,  0, 8'h12, 1'b0, 2'b00, 3));
    vecs.push_back(mk(3'b110, 8'h64, 8'h00, 8'h02, -1, 10, 8'hC8, 1'b1, 2'b00, 3));
    vecs.push_back(mk(3'b000, 8'h11, 8'h22, 8'h00, -1,  0, 8'h00, 1'b0, 2'b01, 1));
    vecs.push_back(mk(3'b111, 8'h11, 8'h22, 8'h00, -1,  0, 8'h00, 1'b0, 2'b01, 1));
    vecs.push_back(mk(3'b011, 8'h07, 8'h07, 8'h00,  5,  0, 8'h55, 1'b0, 2'b00, 7));
    vecs.push_back(mk(3'b011, 8'h07, 8'h07, 8'h00, -1,  0, 8'h00, 1'b0, 2'b10, 10));
    vecs.push_back(mk(3'b001, 8'h03, 8'h04, 8'h00, -1,  0, 8'h07, 1'b0, 2'b00, 3));
    vecs.push_back(mk(3'b011, 8'h07, 8'h07, 8'h00,  8,  0, 8'h55, 1'b0, 2'b00, 10));
    vecs.push_back(mk(3'b011, 8'h07, 8'h07, 8'h00,  9,  0, 8'h00, 1'b0, 2'b10, 10));

    #12;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_busy_valid", {busy, rsp_valid}, 2'b00);
    chk("reset_alu_opcode", alu_opcode, 3'b000);
    chk("reset_rsp", {rsp_C, rsp_overflow, rsp_error}, '0);
    chk("reset_latched", {alu_A, alu_B, alu_f}, '0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("release_cmd_ready", cmd_ready, 1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted mid-WAIT of a multiply that never completes.
    done_at = -1;
    @(negedge clock);
    cmd_opcode = 3'b011;
    cmd_A = {25{8'h07}};
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_wait_pre_opcode", alu_opcode, 3'b011);
    #2 reset = 1'b1;
    #1;
    chk("rst_wait_alu_opcode", alu_opcode, 3'b000);
    chk("rst_wait_flags", {busy, rsp_valid, cmd_ready}, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_wait_cmd_ready", cmd_ready, 1);
    never = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) never = 1'b0;
    end
    chk("rst_wait_no_rsp", never, 1);
    run_vec(100, mk(3'b001, 8'h03, 8'h04, 8'h00, -1, 0, 8'h07, 1'b0, 2'b00, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
